// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states and the IF/ID payload.
package if_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] npc;
        logic                    valid;
    } if_id_t;

endpackage

// File: rtl/if_stage_pipe_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise a bubble.
module if_id_reg
    import if_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] npc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] npc_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] npc_q;
    logic            valid_q;

    // Payload is only written on load; a bubble or flush just clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            npc_q   <= npc_i;
            valid_q <= 1'b1;
        end else if (!hold_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: registered PC, variable-latency imem handshake,
// one-entry hold buffer for decode stalls and squash of in-flight fetches on redirect.
module if_stage_pipe
    import if_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] INCR     = XLEN'(1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_stall,
    input  logic            ex_mem_pcsrc,
    input  logic [XLEN-1:0] ex_mem_npc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_npc,
    output logic            if_id_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_npc_q, hold_npc_d;

    logic [XLEN-1:0] pc_inc;
    logic            blocked;
    logic            ifid_load;
    logic            ifid_hold;
    logic [XLEN-1:0] ifid_instr_in;
    logic [XLEN-1:0] ifid_npc_in;

    assign pc_inc  = pc_q + INCR;
    assign blocked = id_stall && if_id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pending_q    <= '0;
            hold_instr_q <= '0;
            hold_npc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            hold_instr_q <= hold_instr_d;
            hold_npc_q   <= hold_npc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        hold_instr_d  = hold_instr_q;
        hold_npc_d    = hold_npc_q;
        ifid_load     = 1'b0;
        ifid_hold     = 1'b0;
        ifid_instr_in = imem_rdata;
        ifid_npc_in   = pc_inc;

        unique case (state_q)
            RUN: begin
                if (ex_mem_pcsrc) begin
                    // An unacked request must keep its address, so park the target.
                    if (imem_ack) begin
                        pc_d = ex_mem_npc;
                    end else begin
                        pending_d = ex_mem_npc;
                        state_d   = SQUASH;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (blocked) begin
                        hold_instr_d = imem_rdata;
                        hold_npc_d   = pc_inc;
                        ifid_hold    = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else begin
                    ifid_hold = id_stall;
                end
            end
            HOLD: begin
                if (ex_mem_pcsrc) begin
                    pc_d    = ex_mem_npc;
                    state_d = RUN;
                end else if (!id_stall) begin
                    ifid_load     = 1'b1;
                    ifid_instr_in = hold_instr_q;
                    ifid_npc_in   = hold_npc_q;
                    state_d       = RUN;
                end else begin
                    ifid_hold = 1'b1;
                end
            end
            SQUASH: begin
                if (ex_mem_pcsrc) begin
                    if (imem_ack) begin
                        pc_d    = ex_mem_npc;
                        state_d = RUN;
                    end else begin
                        pending_d = ex_mem_npc;
                    end
                end else if (imem_ack) begin
                    pc_d    = pending_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = pc_q;

    if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (ex_mem_pcsrc),
        .hold_i  (ifid_hold),
        .instr_i (ifid_instr_in),
        .npc_i   (ifid_npc_in),
        .instr_o (if_id_instr),
        .npc_o   (if_id_npc),
        .valid_o (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: directed scenarios plus randomized latency/stall/redirect traffic
// checked by a scoreboard of the architectural instruction stream seen by decode.
module tb_if_stage_pipe;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        ex_mem_pcsrc;
    logic [31:0] ex_mem_npc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_npc;
    logic        w_valid;

    always #5 clk = ~clk;

    if_stage_pipe #(.XLEN(32), .RESET_PC(32'h0), .INCR(32'd1)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .ex_mem_pcsrc(ex_mem_pcsrc), .ex_mem_npc(ex_mem_npc),
        .if_id_instr(if_id_instr), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid)
    );

    if_stage_pipe #(.XLEN(32), .RESET_PC(32'hFFFF_FFFF), .INCR(32'd1)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .id_stall(1'b0), .ex_mem_pcsrc(1'b0), .ex_mem_npc(32'h0),
        .if_id_instr(w_instr), .if_id_npc(w_npc), .if_id_valid(w_valid)
    );

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    // Reference: the stream decode should accept is addr, addr+1, ... restarting at each redirect.
    if_id_t      exp_q[$];
    logic [31:0] exp_next;

    int wait_cnt, cur_lat, lat_lo, lat_hi;
    bit mem_block, junk_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{instr: exp_next + 32'h100, npc: exp_next + 32'd1, valid: 1'b1});
            exp_next = exp_next + 32'd1;
        end
    endtask

    task automatic mem_drive();
        if (imem_req) begin
            if (!mem_block && wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr + 32'h100;
                wait_cnt   = 0;
                cur_lat    = int'($urandom_range(lat_hi, lat_lo));
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                if (!mem_block) wait_cnt++;
            end
        end else begin
            imem_ack   = junk_ack ? 1'($urandom_range(1, 0)) : 1'b0;
            imem_rdata = $urandom;
            wait_cnt   = 0;
        end
        w_rdata = w_addr + 32'h100;
    endtask

    task automatic step();
        @(negedge clk);
        if (ex_mem_pcsrc && !rst) begin
            exp_q.delete();
            exp_next = ex_mem_npc;
        end
        ex_mem_pcsrc = 1'b0;
        top_up();
        mem_drive();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        ex_mem_pcsrc = 1'b0;
        id_stall     = 1'b0;
        imem_ack     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_npc",   if_id_npc, 32'h0);
        chk("rst_waddr", w_addr, 32'hFFFF_FFFF);
        rst = 1'b0;
        exp_q.delete();
        exp_next = 32'h0;
        top_up();
        wait_cnt = 0;
        cur_lat  = int'($urandom_range(lat_hi, lat_lo));
        #1;
        mem_drive();
    endtask

    // Monitor: samples just before each rising edge, pops on every decode acceptance.
    bit          prev_pend, prev_redir;
    logic [31:0] prev_addr;
    initial begin
        if_id_t e;
        prev_pend  = 1'b0;
        prev_redir = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_pend  = 1'b0;
                prev_redir = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("unacked_req_held", 32'(imem_req), 32'd1);
                    chk("unacked_addr_stable", imem_addr, prev_addr);
                end
                if (prev_redir) chk("valid_after_redirect", 32'(if_id_valid), 32'd0);
                if (if_id_valid && !id_stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty: got instr 0x%08h expected none", if_id_instr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_instr", if_id_instr, e.instr);
                        chk("sb_npc", if_id_npc, e.npc);
                        consumed++;
                    end
                end
                prev_pend  = imem_req && !imem_ack;
                prev_addr  = imem_addr;
                prev_redir = ex_mem_pcsrc;
            end
        end
    end

    initial begin
        rst = 1'b1; id_stall = 1'b0; ex_mem_pcsrc = 1'b0; ex_mem_npc = '0;
        imem_ack = 1'b0; imem_rdata = '0; w_ack = 1'b1; w_rdata = '0;
        lat_lo = 0; lat_hi = 0; mem_block = 1'b0; junk_ack = 1'b0;
        wait_cnt = 0; cur_lat = 0;

        // Zero-wait streaming, plus PC wrap on the second instance.
        do_reset();
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("zw_addr", imem_addr, 32'(i));
            if (i > 0) begin
                chk("zw_instr", if_id_instr, 32'h100 + 32'(i - 1));
                chk("zw_npc", if_id_npc, 32'(i));
                chk("zw_valid", 32'(if_id_valid), 32'd1);
            end else begin
                chk("zw_first_bubble", 32'(if_id_valid), 32'd0);
            end
            if (i == 1) begin
                chk("wrap_second_addr", w_addr, 32'h0);
                chk("wrap_instr", w_instr, 32'hFF);
                chk("wrap_npc", w_npc, 32'h0);
            end
            step();
        end

        // Two wait states: one instruction every three cycles.
        lat_lo = 2; lat_hi = 2;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            chk("w2_addr", imem_addr, 32'(c / 3));
            chk("w2_valid", 32'(if_id_valid), 32'(c > 0 && c % 3 == 0));
            step();
        end

        // Decode stall while an ack arrives -> HOLD, then replay of the buffered entry.
        lat_lo = 0; lat_hi = 0;
        do_reset();
        repeat (2) step();
        chk("st_pre_instr", if_id_instr, 32'h101);
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) id_stall = 1'b0;
            chk("st_hold_req", 32'(imem_req), 32'd0);
            chk("st_hold_instr", if_id_instr, 32'h101);
            chk("st_hold_valid", 32'(if_id_valid), 32'd1);
        end
        step();
        chk("st_buf_instr", if_id_instr, 32'h102);
        chk("st_buf_npc", if_id_npc, 32'h3);
        chk("st_resume_addr", imem_addr, 32'h3);
        chk("st_resume_req", 32'(imem_req), 32'd1);

        // Redirect to 0x40 while the fetch at pc=5 is unacked.
        do_reset();
        repeat (4) step();
        mem_block = 1'b1;
        step();
        chk("sq_addr_at_redirect", imem_addr, 32'h5);
        ex_mem_pcsrc = 1'b1; ex_mem_npc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_block = 1'b0; cur_lat = 0; end
            step();
            chk("sq_addr_held", imem_addr, 32'h5);
            chk("sq_req", 32'(imem_req), 32'd1);
            chk("sq_valid", 32'(if_id_valid), 32'd0);
        end
        step();
        chk("sq_target_addr", imem_addr, 32'h40);
        chk("sq_target_bubble", 32'(if_id_valid), 32'd0);
        step();
        chk("sq_target_instr", if_id_instr, 32'h140);
        chk("sq_target_npc", if_id_npc, 32'h41);

        // Back-to-back redirects while squashing: the last target wins.
        mem_block = 1'b1;
        step();
        ex_mem_pcsrc = 1'b1; ex_mem_npc = 32'h70;
        step();
        ex_mem_pcsrc = 1'b1; ex_mem_npc = 32'h80;
        step();
        ex_mem_pcsrc = 1'b1; ex_mem_npc = 32'h90;
        mem_block = 1'b0; cur_lat = 0;
        step();
        chk("sq2_addr_held", imem_addr, 32'h42);
        step();
        chk("sq2_last_target", imem_addr, 32'h90);
        step();
        chk("sq2_instr", if_id_instr, 32'h190);

        // Redirect under stall (RUN with ack, then HOLD) still flushes IF/ID.
        id_stall = 1'b1; ex_mem_pcsrc = 1'b1; ex_mem_npc = 32'h200;
        step();
        chk("rs_valid", 32'(if_id_valid), 32'd0);
        chk("rs_addr", imem_addr, 32'h200);
        id_stall = 1'b0;
        step();
        chk("rs_instr", if_id_instr, 32'h300);
        id_stall = 1'b1;
        step();
        chk("rh_hold_req", 32'(imem_req), 32'd0);
        ex_mem_pcsrc = 1'b1; ex_mem_npc = 32'h300;
        step();
        chk("rh_valid", 32'(if_id_valid), 32'd0);
        chk("rh_addr", imem_addr, 32'h300);
        id_stall = 1'b0;

        // Randomized latency, stalls, redirects and stray acks while idle.
        lat_lo = 0; lat_hi = 3; junk_ack = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step();
            id_stall = ($urandom_range(99, 0) < 30);
            if ($urandom_range(99, 0) < 6) begin
                ex_mem_pcsrc = 1'b1;
                ex_mem_npc   = $urandom;
            end
        end

        // Asynchronous reset mid-fetch.
        @(negedge clk);
        ex_mem_pcsrc = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", 32'(if_id_valid), 32'd0);
        chk("arst_instr", if_id_instr, 32'h0);
        chk("arst_npc", if_id_npc, 32'h0);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            step();
            id_stall = ($urandom_range(99, 0) < 25);
            if ($urandom_range(99, 0) < 5) begin
                ex_mem_pcsrc = 1'b1;
                ex_mem_npc   = $urandom;
            end
        end
        step();
        id_stall = 1'b0;
        repeat (3) step();

        checks++;
        if (consumed < 300) begin
            failures++;
            $display("FAIL throughput: got %0d accepted instructions expected at least 300", consumed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
